// File: rtl/bkm_iter_ctrl_pkg.sv
// Shared definitions for the BKM iteration sequencer.
//   bkm_state_t : controller states (2-bit encoding)
//   BKM_MODE_*  : BKM mode select values carried on mode / mode_q
package bkm_iter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bkm_state_t;

    localparam logic BKM_MODE_E = 1'b0;
    localparam logic BKM_MODE_L = 1'b1;

endpackage

// File: rtl/bkm_iter_ctrl_lat_cnt.sv
// bkm_lat_cnt: counts the bkm_step latency, 0..LAT-1, wrapping at terminal count.
//   clk, arst(active-low async), enable (clock enable), srst (sync reset),
//   clr   : force count to 0 on an enabled edge
//   inc   : advance count on an enabled edge (wraps to 0 after LAT-1)
//   tc    : terminal count, cnt == LAT-1
module bkm_lat_cnt #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned LAT_W = $clog2(LAT + 1)
) (
    input  logic clk,
    input  logic arst,
    input  logic enable,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [LAT_W-1:0] LAST = LAT_W'(LAT - 1);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt <= '0;
        end else if (enable) begin
            if (srst || clr || (inc && tc)) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/bkm_iter_ctrl.sv
// bkm_iter_ctrl: sequencer for the BKM iteration datapath.
// Accepts a start, loads the initial operands for one cycle, then runs N_ITER
// steps, each qualified LAT cycles after the previous one, and holds the
// result valid until the consumer takes it.
//   in : clk, arst (async, active-low), srst (sync, active-high), enable,
//        start, mode, abort, out_ready
//   out: ready, busy, sel_init, step_en, lut_addr[CNT_W], mode_q, out_valid
module bkm_iter_ctrl
    import bkm_iter_ctrl_pkg::*;
#(
    parameter int unsigned N_ITER = 64,
    parameter int unsigned LAT    = 1,
    parameter int unsigned CNT_W  = $clog2(N_ITER),
    parameter int unsigned LAT_W  = $clog2(LAT + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             out_ready,
    output logic             ready,
    output logic             busy,
    output logic             sel_init,
    output logic             step_en,
    output logic [CNT_W-1:0] lut_addr,
    output logic             mode_q,
    output logic             out_valid
);

    bkm_state_t       state, state_nxt;
    logic [CNT_W-1:0] n;
    logic             lat_tc;
    logic             last_iter;
    logic             step_done;

    assign last_iter = (n == CNT_W'(N_ITER - 1));
    assign step_done = (state == ST_RUN) && lat_tc;

    bkm_lat_cnt #(
        .LAT   (LAT),
        .LAT_W (LAT_W)
    ) u_lat_cnt (
        .clk    (clk),
        .arst   (arst),
        .enable (enable),
        .srst   (srst),
        .clr    ((state != ST_RUN) || abort),
        .inc    (state == ST_RUN),
        .tc     (lat_tc)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= ST_IDLE;
        end else if (enable) begin
            state <= srst ? ST_IDLE : state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_LOAD;
            ST_LOAD:                state_nxt = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort)                        state_nxt = ST_IDLE;
                else if (lat_tc && last_iter)     state_nxt = ST_DONE;
            end
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // n is only non-zero while staying in RUN, so it is cleared on every
    // other path (start, abort, final step, DONE) and never leaves 0..N_ITER-1.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            n      <= '0;
            mode_q <= BKM_MODE_E;
        end else if (enable) begin
            if (srst || (state_nxt != ST_RUN)) begin
                n <= '0;
            end else if (step_done) begin
                n <= n + 1'b1;
            end

            if (srst) begin
                mode_q <= BKM_MODE_E;
            end else if ((state == ST_IDLE) && start) begin
                mode_q <= mode;
            end
        end
    end

    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        sel_init  = 1'b0;
        step_en   = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: ready = 1'b1;
            ST_LOAD: begin
                busy     = 1'b1;
                sel_init = 1'b1;
                step_en  = 1'b1;
            end
            ST_RUN: begin
                busy    = 1'b1;
                step_en = lat_tc;
            end
            ST_DONE: out_valid = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign lut_addr = n;

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Scoreboard bench for bkm_iter_ctrl (N_ITER=4, LAT=2) plus a default-parameter
// instance. Operations are described by cycle arithmetic relative to the
// accepting edge; enabled edges are counted so enable pauses stretch time.
module tb_bkm_iter_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned L  = 2;
    localparam int unsigned DN = 64;
    localparam int unsigned DL = 1;
    localparam int unsigned DONE_REL = 2 + N * L;

    logic       clk = 1'b0;
    logic       arst, srst, enable, start, mode, abort, out_ready;
    logic       ready, busy, sel_init, step_en, mode_q, out_valid;
    logic [1:0] lut_addr;

    logic       d_start, d_mode, d_abort, d_out_ready;
    logic       d_ready, d_busy, d_sel_init, d_step_en, d_mode_q, d_out_valid;
    logic [5:0] d_lut_addr;

    typedef struct {
        bit          done;
        int unsigned at;
        logic [1:0]  addr;
        logic        sel;
        logic        mq;
    } ev_t;

    ev_t         sbq[$];
    int unsigned ecount = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_on = 1'b0;
    logic        ov_prev = 1'b0;

    bkm_iter_ctrl #(.N_ITER(N), .LAT(L)) u_dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .start(start), .mode(mode), .abort(abort), .out_ready(out_ready),
        .ready(ready), .busy(busy), .sel_init(sel_init), .step_en(step_en),
        .lut_addr(lut_addr), .mode_q(mode_q), .out_valid(out_valid)
    );

    bkm_iter_ctrl u_dflt (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .start(d_start), .mode(d_mode), .abort(d_abort), .out_ready(d_out_ready),
        .ready(d_ready), .busy(d_busy), .sel_init(d_sel_init), .step_en(d_step_en),
        .lut_addr(d_lut_addr), .mode_q(d_mode_q), .out_valid(d_out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (arst && enable) ecount <= ecount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sel_init"}, sel_init, 0);
        check({tag, "_step_en"}, step_en, 0);
        check({tag, "_lut_addr"}, lut_addr, 0);
        check({tag, "_mode_q"}, mode_q, 0);
        check({tag, "_out_valid"}, out_valid, 0);
    endtask

    // Monitor: a step is consumed by the datapath on an enabled edge with step_en=1.
    always @(negedge clk) begin
        ev_t ev;
        if (arst && mon_on && !srst) begin
            if (step_en && enable && !abort) begin
                if (sbq.size() == 0 || sbq[0].done) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_step: got step_en=1 at %0d expected none", ecount);
                end else begin
                    ev = sbq.pop_front();
                    check("step_time", ecount, ev.at);
                    check("step_lut_addr", lut_addr, ev.addr);
                    check("step_sel_init", sel_init, ev.sel);
                    check("step_mode_q", mode_q, ev.mq);
                end
            end
            if (out_valid && !ov_prev) begin
                if (sbq.size() == 0 || !sbq[0].done) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_valid: got out_valid=1 at %0d expected none", ecount);
                end else begin
                    ev = sbq.pop_front();
                    check("valid_time", ecount, ev.at);
                    check("valid_mode_q", mode_q, ev.mq);
                end
            end
        end
        ov_prev = out_valid;
    end

    // One operation; called at posedge+2 with the DUT idle.
    task automatic run_op(input bit do_abort, input int unsigned abort_rel, input int unsigned pen);
        int unsigned b, rel;
        bit          m, fin, ok;
        ev_t         ev;
        m = 1'($urandom_range(0, 1));
        b = ecount;
        start = 1'b1; mode = m; enable = 1'b1; abort = 1'b0; out_ready = 1'b0;
        for (int unsigned k = 0; k <= N; k++) begin
            ev.done = 1'b0;
            ev.at   = b + 1 + k * L;
            ev.addr = (k == 0) ? 2'd0 : 2'(k - 1);
            ev.sel  = (k == 0);
            ev.mq   = m;
            if (!do_abort || (k * L + 1 < abort_rel)) sbq.push_back(ev);
        end
        if (!do_abort) begin
            ev.done = 1'b1; ev.at = b + DONE_REL; ev.addr = 2'd0; ev.sel = 1'b0; ev.mq = m;
            sbq.push_back(ev);
        end
        @(posedge clk); #2;
        start = 1'b0;
        ok = 1'b0;
        for (int it = 0; it < 2000; it++) begin
            rel = ecount - b;
            check("op_busy", busy, (rel >= 1 && rel < DONE_REL) ? 1 : 0);
            check("op_ready", ready, 0);
            check("op_out_valid", out_valid, (rel >= DONE_REL) ? 1 : 0);
            fin       = 1'b0;
            enable    = ($urandom_range(0, 99) >= pen);
            start     = ($urandom_range(0, 9) == 0);
            mode      = 1'($urandom_range(0, 1));
            abort     = 1'b0;
            out_ready = 1'b0;
            if (do_abort && rel == abort_rel) begin
                enable = 1'b1; abort = 1'b1; fin = 1'b1;
            end else if (rel >= DONE_REL) begin
                abort     = ($urandom_range(0, 4) == 0);
                out_ready = ($urandom_range(0, 2) == 0);
                fin       = out_ready && enable;
            end
            @(posedge clk); #2;
            if (fin) begin ok = 1'b1; break; end
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0; enable = 1'b1;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL op_timeout: got no completion expected completion within 2000 cycles");
        end
        check("post_ready", ready, 1);
        check("post_busy", busy, 0);
        check("post_out_valid", out_valid, 0);
    endtask

    initial begin
        int unsigned pulses;
        arst = 1'b0; srst = 1'b0; enable = 1'b0; start = 1'b0; mode = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        d_start = 1'b0; d_mode = 1'b0; d_abort = 1'b0; d_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_vals("reset");
        arst = 1'b1;
        mon_on = 1'b1;

        run_op(1'b0, 0, 0);          // clean run, exact timing
        run_op(1'b1, 4, 0);          // abort in cycle 4
        run_op(1'b1, 1, 0);          // abort during LOAD
        run_op(1'b0, 0, 40);         // enable pauses
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0)
                run_op(1'b1, $urandom_range(1, DONE_REL - 1), $urandom_range(0, 40));
            else
                run_op(1'b0, 0, $urandom_range(0, 40));
        end
        check("queue_drained", sbq.size(), 0);

        // Asynchronous reset mid-operation.
        mon_on = 1'b0;
        start = 1'b1; mode = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_arst_busy", busy, 1);
        arst = 1'b0;
        #1;
        check_reset_vals("arst");
        @(posedge clk); #2;
        arst = 1'b1;

        // Sync reset: ignored while disabled, wins over abort when enabled.
        start = 1'b1; mode = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        enable = 1'b0; srst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("srst_disabled_busy", busy, 1);
        check("srst_disabled_mode_q", mode_q, 1);
        enable = 1'b1; abort = 1'b1;
        @(posedge clk); #2;
        srst = 1'b0; abort = 1'b0;
        check_reset_vals("srst");
        sbq.delete();
        ov_prev = 1'b0;
        mon_on = 1'b1;

        // Default parameters, L-mode.
        d_start = 1'b1; d_mode = 1'b1;
        @(posedge clk); #2;
        d_start = 1'b0; d_mode = 1'b0;
        pulses = 0;
        for (int unsigned c = 1; c <= 2 + DN * DL; c++) begin
            pulses += d_step_en;
            if (c == 1 + DN * DL) begin
                check("dflt_final_lut_addr", d_lut_addr, DN - 1);
                check("dflt_final_step_en", d_step_en, 1);
                check("dflt_pre_valid", d_out_valid, 0);
            end
            if (c == 2 + DN * DL) begin
                check("dflt_out_valid", d_out_valid, 1);
                check("dflt_mode_q", d_mode_q, 1);
            end
            @(posedge clk); #2;
        end
        check("dflt_step_pulses", pulses, DN + 1);
        d_out_ready = 1'b1;
        @(posedge clk); #2;
        d_out_ready = 1'b0;
        check("dflt_ready_after", d_ready, 1);
        check("dflt_valid_after", d_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
